traffic_light_ctrl: RTL and testbench

TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

---
 rtl/traffic_light_ctrl.sv | 142 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: six-phase NS/EW cycle timed in watch-second ticks, with emergency all-red hold.
// All outputs are registered; an emergency request cuts a green short, and a RED phase then parks in EMG_HOLD.
module traffic_light_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       day_or_night,
  input  logic       emg,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic [2:0] phase,
  output logic [4:0] remain,
  output logic       emg_active
);

  typedef enum logic [2:0] {
    NS_G     = 3'd0,
    NS_Y     = 3'd1,
    RED1     = 3'd2,
    EW_G     = 3'd3,
    EW_Y     = 3'd4,
    RED2     = 3'd5,
    EMG_HOLD = 3'd6,
    ST_BAD   = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  state_t     r_state;
  logic [4:0] r_remain;
  logic [2:0] r_ns_light;
  logic [2:0] r_ew_light;
  logic       r_emg_active;

  state_t     w_succ;
  state_t     w_nxt_state;
  logic [4:0] w_nxt_remain;
  logic       w_expire;

  function automatic logic [4:0] f_dur(input state_t s, input logic night);
    case (s)
      NS_G, EW_G: f_dur = night ? 5'd5 : 5'd15;
      NS_Y, EW_Y: f_dur = night ? 5'd1 : 5'd3;
      default:    f_dur = 5'd1;
    endcase
  endfunction

  function automatic logic [2:0] f_ns_lamp(input state_t s);
    case (s)
      NS_G:    f_ns_lamp = LAMP_G;
      NS_Y:    f_ns_lamp = LAMP_Y;
      default: f_ns_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] f_ew_lamp(input state_t s);
    case (s)
      EW_G:    f_ew_lamp = LAMP_G;
      EW_Y:    f_ew_lamp = LAMP_Y;
      default: f_ew_lamp = LAMP_R;
    endcase
  endfunction

  always_comb begin
    w_succ = RED2;
    case (r_state)
      NS_G:    w_succ = NS_Y;
      NS_Y:    w_succ = RED1;
      RED1:    w_succ = EW_G;
      EW_G:    w_succ = EW_Y;
      EW_Y:    w_succ = RED2;
      RED2:    w_succ = NS_G;
      default: w_succ = RED2;
    endcase
  end

  // remain <= 1 rather than == 1 so a corrupted zero count still advances instead of wrapping.
  assign w_expire = sec_tick && (r_remain <= 5'd1);

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_remain = r_remain;
    case (r_state)
      EMG_HOLD: begin
        w_nxt_remain = 5'd0;
        if (!emg) begin
          w_nxt_state  = NS_G;
          w_nxt_remain = f_dur(NS_G, day_or_night);
        end
      end
      NS_G, EW_G, NS_Y, EW_Y: begin
        if ((emg && (r_state == NS_G || r_state == EW_G)) || w_expire) begin
          w_nxt_state  = w_succ;
          w_nxt_remain = f_dur(w_succ, day_or_night);
        end else if (sec_tick) begin
          w_nxt_remain = r_remain - 5'd1;
        end
      end
      RED1, RED2: begin
        if (w_expire && emg) begin
          w_nxt_state  = EMG_HOLD;
          w_nxt_remain = 5'd0;
        end else if (w_expire) begin
          w_nxt_state  = w_succ;
          w_nxt_remain = f_dur(w_succ, day_or_night);
        end else if (sec_tick) begin
          w_nxt_remain = r_remain - 5'd1;
        end
      end
      default: begin
        w_nxt_state  = RED2;
        w_nxt_remain = 5'd1;
      end
    endcase
  end

  // Lamps are decoded from the next state so they land in the same edge as phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RED2;
      r_remain     <= 5'd1;
      r_ns_light   <= LAMP_R;
      r_ew_light   <= LAMP_R;
      r_emg_active <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_remain     <= w_nxt_remain;
      r_ns_light   <= f_ns_lamp(w_nxt_state);
      r_ew_light   <= f_ew_lamp(w_nxt_state);
      r_emg_active <= (w_nxt_state == EMG_HOLD);
    end
  end

  assign phase      = r_state;
  assign remain     = r_remain;
  assign ns_light   = r_ns_light;
  assign ew_light   = r_ew_light;
  assign emg_active = r_emg_active;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios plus randomized ticks/mode/emergency,
// all checked each cycle against a table-driven phase model.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sec_tick = 1'b0;
  logic       day_or_night = 1'b0;
  logic       emg = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;
  logic [4:0] remain;
  logic       emg_active;

  int n_checks = 0;
  int n_errors = 0;

  // Model: m_ph is 0..5 for the normal cycle (sequence index), 6 for emergency hold.
  int m_ph  = 5;
  int m_rem = 1;

  traffic_light_ctrl dut (
    .clk(clk), .rst(rst), .sec_tick(sec_tick), .day_or_night(day_or_night), .emg(emg),
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase), .remain(remain),
    .emg_active(emg_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int dur(input int ph, input logic night);
    int d_day[6]   = '{15, 3, 1, 15, 3, 1};
    int d_night[6] = '{5, 1, 1, 5, 1, 1};
    return night ? d_night[ph] : d_day[ph];
  endfunction

  function automatic int lamp_ns(input int ph);
    return (ph == 0) ? 1 : (ph == 1) ? 2 : 4;
  endfunction

  function automatic int lamp_ew(input int ph);
    return (ph == 3) ? 1 : (ph == 4) ? 2 : 4;
  endfunction

  task automatic model_step(input logic t, input logic dn, input logic e);
    if (m_ph == 6) begin
      if (!e) begin
        m_ph  = 0;
        m_rem = dur(0, dn);
      end
    end else if (e && (m_ph == 0 || m_ph == 3)) begin
      m_ph  = m_ph + 1;
      m_rem = dur(m_ph, dn);
    end else if (t) begin
      if (m_rem == 1) begin
        if (e && (m_ph == 2 || m_ph == 5)) begin
          m_ph  = 6;
          m_rem = 0;
        end else begin
          m_ph  = (m_ph + 1) % 6;
          m_rem = dur(m_ph, dn);
        end
      end else begin
        m_rem = m_rem - 1;
      end
    end
  endtask

  task automatic compare();
    chk("phase", phase, m_ph);
    chk("remain", remain, m_rem);
    chk("ns_light", ns_light, lamp_ns(m_ph));
    chk("ew_light", ew_light, lamp_ew(m_ph));
    chk("emg_active", emg_active, (m_ph == 6) ? 1 : 0);
    chk("ns_onehot", $countones(ns_light), 1);
    chk("ew_onehot", $countones(ew_light), 1);
    chk("no_conflict", (ns_light != 3'b100 && ew_light != 3'b100) ? 1 : 0, 0);
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic step(input logic t, input logic dn, input logic e);
    sec_tick     = t;
    day_or_night = dn;
    emg          = e;
    @(posedge clk);
    model_step(t, dn, e);
    @(negedge clk);
    sec_tick = 1'b0;
    compare();
  endtask

  task automatic ticks(input int n, input logic dn, input logic e);
    for (int i = 0; i < n; i++) step(1'b1, dn, e);
  endtask

  task automatic apply_reset();
    sec_tick = 1'b0;
    emg      = 1'b0;
    rst      = 1'b0;
    #1;
    chk("rst_phase", phase, 5);
    chk("rst_remain", remain, 1);
    chk("rst_ns", ns_light, 4);
    chk("rst_ew", ew_light, 4);
    chk("rst_emg_active", emg_active, 0);
    m_ph  = 5;
    m_rem = 1;
    @(negedge clk);
    rst = 1'b1;
    compare();
  endtask

  // Reset, then walk to EW_G (fresh day duration).
  task automatic to_ew_g();
    apply_reset();
    ticks(1, 1'b0, 1'b0);
    ticks(15 + 3 + 1, 1'b0, 1'b0);
    chk("reach_ew_g", phase, 3);
  endtask

  // Counts ticks spent in each phase from the outputs alone, a tick every 10 clocks.
  task automatic run_cycle(input logic dn, input int nticks);
    int exp_d[6];
    int cnt = 0;
    int tot = 0;
    int prev;
    bit started = 0;
    bit started_tot = 0;
    logic t;
    if (dn) exp_d = '{5, 1, 1, 5, 1, 1};
    else    exp_d = '{15, 3, 1, 15, 3, 1};
    for (int k = 0; k < nticks * 10; k++) begin
      t    = (k % 10 == 9);
      prev = phase;
      step(t, dn, 1'b0);
      if (t) begin
        cnt++;
        tot++;
      end
      if (phase != prev) begin
        if (started && prev < 6) chk(dn ? "night_dur" : "day_dur", cnt, exp_d[prev]);
        cnt     = 0;
        started = 1;
        if (phase == 0) begin
          if (started_tot) chk(dn ? "night_cycle" : "day_cycle", tot, dn ? 14 : 38);
          tot         = 0;
          started_tot = 1;
        end
      end
    end
  endtask

  initial begin
    logic r_dn;
    logic r_e;
    repeat (2) @(negedge clk);
    apply_reset();

    run_cycle(1'b0, 1 + 38 * 2);
    apply_reset();
    run_cycle(1'b1, 1 + 14 * 2);

    // Mode flip mid-green keeps the running NS_G at its day length.
    apply_reset();
    ticks(1, 1'b0, 1'b0);
    ticks(4, 1'b0, 1'b0);
    ticks(10, 1'b1, 1'b0);
    chk("mode_ns_g_held", phase, 0);
    ticks(1, 1'b1, 1'b0);
    chk("mode_ns_y", phase, 1);
    chk("mode_ns_y_rem", remain, 1);

    // Emergency during NS_G, coincident tick.
    apply_reset();
    ticks(1, 1'b0, 1'b0);
    ticks(6, 1'b0, 1'b0);
    chk("emg_pre_rem", remain, 9);
    step(1'b1, 1'b0, 1'b1);
    chk("emg_ns_y", phase, 1);
    chk("emg_ns_y_rem", remain, 3);
    ticks(3, 1'b0, 1'b1);
    chk("emg_red1", phase, 2);
    ticks(1, 1'b0, 1'b1);
    chk("emg_hold", phase, 6);
    ticks(20, 1'b0, 1'b1);
    chk("emg_hold_stay", emg_active, 1);
    chk("emg_hold_rem", remain, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("emg_exit", phase, 0);
    chk("emg_exit_rem", remain, 15);

    // One-clock emergency pulse in EW_G.
    to_ew_g();
    step(1'b0, 1'b0, 1'b1);
    chk("pulse_ew_y", phase, 4);
    ticks(3, 1'b0, 1'b0);
    chk("pulse_red2", phase, 5);
    ticks(1, 1'b0, 1'b0);
    chk("pulse_ns_g", phase, 0);

    // Reset mid-phase.
    to_ew_g();
    ticks(8, 1'b0, 1'b0);
    chk("mid_rem", remain, 7);
    apply_reset();
    ticks(1, 1'b0, 1'b0);
    chk("post_rst_ns_g", phase, 0);

    // Randomized traffic.
    r_dn = 1'b0;
    r_e  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) r_dn = ~r_dn;
      if ($urandom_range(0, 39) == 0) r_e = ~r_e;
      if ($urandom_range(0, 999) == 0) apply_reset();
      else step($urandom_range(0, 2) == 0, r_dn, r_e);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
